// File: rtl/error_scan_pkg.sv
// -----------------------------------------------------------------------------
// error_scan_pkg
//
// Purpose : Shared definitions for the error-counter scanner slice. Holds the
//           scan state enumeration and the default sizing constants used by
//           error_counter_scanner and its one-hot decoder.
//
// Contents:
//   DEF_NUM_CNT  - default number of error counters in the bank
//   DEF_CNT_W    - default counter width (also the shared count bus width)
//   DEF_IDX_W    - default counter index width (2**IDX_W >= NUM_CNT)
//   scan_state_e - IDLE, SELECT, PRESENT, CLEAR, DONE
//
// Optional feature macro used by this slice: ERR_SCAN_SKIP_ZERO_EN
// -----------------------------------------------------------------------------
package error_scan_pkg;

   localparam int DEF_NUM_CNT = 8;
   localparam int DEF_CNT_W   = 10;
   localparam int DEF_IDX_W   = 3;

   // IDLE    : waiting for a scan request
   // SELECT  : read enable of the current counter is high, bus settles
   // PRESENT : captured {index, count} offered downstream until acked
   // CLEAR   : one-cycle clear pulse to the counter just read
   // DONE    : one-cycle end-of-scan indication
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SELECT  = 3'd1,
      PRESENT = 3'd2,
      CLEAR   = 3'd3,
      DONE    = 3'd4
   } scan_state_e;

endpackage : error_scan_pkg

// File: rtl/error_scan_onehot_dec.sv
// -----------------------------------------------------------------------------
// error_scan_onehot_dec
//
// Purpose : Decodes the current counter index into the one-hot read-enable
//           and clear-pulse vectors that drive the counter bank. Each vector
//           is all-zero unless its enable is high, so at most one counter
//           ever drives the shared bus or sees a clear.
//
// Ports:
//   idx       in  IDX_W    index of the counter being addressed
//   read_en   in  1        request a read enable for counter idx
//   clear_en  in  1        request a clear pulse for counter idx
//   read_vec  out NUM_CNT  one-hot read enables
//   clear_vec out NUM_CNT  one-hot clear pulses
//
// Optional feature macro used by this slice: ERR_SCAN_SKIP_ZERO_EN (not
// referenced here).
// -----------------------------------------------------------------------------
module error_scan_onehot_dec
   import error_scan_pkg::*;
#(
   parameter int NUM_CNT = DEF_NUM_CNT,
   parameter int IDX_W   = DEF_IDX_W
) (
   input  logic [IDX_W-1:0]   idx,
   input  logic               read_en,
   input  logic               clear_en,
   output logic [NUM_CNT-1:0] read_vec,
   output logic [NUM_CNT-1:0] clear_vec
);

   // Indices at or above NUM_CNT match no bit, so an out-of-range index
   // can never select a counter.
   always_comb begin
      read_vec  = '0;
      clear_vec = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (idx == IDX_W'(i)) begin
            read_vec[i]  = read_en;
            clear_vec[i] = clear_en;
         end
      end
   end

endmodule : error_scan_onehot_dec

// File: rtl/error_counter_scanner.sv
// -----------------------------------------------------------------------------
// error_counter_scanner
//
// Purpose : Walks a bank of NUM_CNT error counters that share one count bus.
//           For each counter in index order it raises that counter's read
//           enable for one cycle, captures the bus, and offers {index, count}
//           downstream with a valid/ack handshake. When ClearOnRead was high
//           at scan start, each counter gets a one-cycle clear pulse after it
//           is acked. Independently, AnyError is the registered OR of the
//           masked per-counter error flags.
//
// Ports:
//   Clk           in  1        clock, rising edge
//   Reset         in  1        asynchronous, active-low reset
//   ScanStart     in  1        start request, honoured only in IDLE
//   ScanAbort     in  1        level abort, ends the scan at once, no clear
//   ClearOnRead   in  1        clear each counter after ack (latched at start)
//   ErrorCountBus in  CNT_W    shared count bus, driven by selected counter
//   ErrorOutVec   in  NUM_CNT  masked per-counter error flags
//   ErrorRead     out NUM_CNT  one-hot read enables
//   ErrorReset    out NUM_CNT  one-hot one-cycle clear pulses
//   DataValid     out 1        DataIdx/DataCount hold a captured value
//   DataIdx       out IDX_W    index of presented counter
//   DataCount     out CNT_W    captured count
//   DataAck       in  1        consumer accept, effective while DataValid
//   Busy          out 1        high in every state except IDLE
//   ScanDone      out 1        one-cycle pulse after the last counter
//   AnyError      out 1        registered OR of ErrorOutVec
//
// Optional feature macro: ERR_SCAN_SKIP_ZERO_EN
//   Defined   : a captured count of zero is not presented and not cleared;
//               the scan moves straight on to the next counter.
//   Undefined : every counter is presented, zero counts included.
// -----------------------------------------------------------------------------
module error_counter_scanner
   import error_scan_pkg::*;
#(
   parameter int NUM_CNT = DEF_NUM_CNT,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int IDX_W   = DEF_IDX_W
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               ScanStart,
   input  logic               ScanAbort,
   input  logic               ClearOnRead,
   input  logic [CNT_W-1:0]   ErrorCountBus,
   input  logic [NUM_CNT-1:0] ErrorOutVec,
   output logic [NUM_CNT-1:0] ErrorRead,
   output logic [NUM_CNT-1:0] ErrorReset,
   output logic               DataValid,
   output logic [IDX_W-1:0]   DataIdx,
   output logic [CNT_W-1:0]   DataCount,
   input  logic               DataAck,
   output logic               Busy,
   output logic               ScanDone,
   output logic               AnyError
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT - 1);

   scan_state_e        state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               cor_q, cor_d;
   logic               valid_q, valid_d;
   logic [IDX_W-1:0]   data_idx_q, data_idx_d;
   logic [CNT_W-1:0]   data_count_q, data_count_d;
   logic               any_error_q, any_error_d;

   // Where the scan goes once the current counter is finished with.
   scan_state_e        adv_state;
   logic [IDX_W-1:0]   adv_idx;
   logic               at_last;

   logic               read_en;
   logic               clear_en;

   // -------------------------------------------------------------------------
   // State register and all datapath flops
   // -------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         cor_q        <= 1'b0;
         valid_q      <= 1'b0;
         data_idx_q   <= '0;
         data_count_q <= '0;
         any_error_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cor_q        <= cor_d;
         valid_q      <= valid_d;
         data_idx_q   <= data_idx_d;
         data_count_q <= data_count_d;
         any_error_q  <= any_error_d;
      end
   end

   // -------------------------------------------------------------------------
   // Advance step shared by PRESENT, CLEAR and (optionally) SELECT. The index
   // saturates at the last counter rather than wrapping.
   // -------------------------------------------------------------------------
   assign at_last = (idx_q == LAST_IDX);

   always_comb begin
      adv_state = SELECT;
      adv_idx   = idx_q + IDX_W'(1);
      if (at_last) begin
         adv_state = DONE;
         adv_idx   = idx_q;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and datapath update
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cor_d        = cor_q;
      valid_d      = valid_q;
      data_idx_d   = data_idx_q;
      data_count_d = data_count_q;
      any_error_d  = |ErrorOutVec;

      // Abort outranks everything, including an ack arriving in the same
      // cycle, so the counter being presented is never cleared.
      if ((state_q != IDLE) && ScanAbort) begin
         state_d = IDLE;
         valid_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (ScanStart && !ScanAbort) begin
                  idx_d   = '0;
                  cor_d   = ClearOnRead;
                  state_d = SELECT;
               end
            end

            SELECT: begin
`ifdef ERR_SCAN_SKIP_ZERO_EN
               if (ErrorCountBus == '0) begin
                  state_d = adv_state;
                  idx_d   = adv_idx;
               end else begin
                  data_count_d = ErrorCountBus;
                  data_idx_d   = idx_q;
                  valid_d      = 1'b1;
                  state_d      = PRESENT;
               end
`else
               data_count_d = ErrorCountBus;
               data_idx_d   = idx_q;
               valid_d      = 1'b1;
               state_d      = PRESENT;
`endif
            end

            PRESENT: begin
               if (DataAck) begin
                  valid_d = 1'b0;
                  if (cor_q) begin
                     state_d = CLEAR;
                  end else begin
                     state_d = adv_state;
                     idx_d   = adv_idx;
                  end
               end
            end

            CLEAR: begin
               state_d = adv_state;
               idx_d   = adv_idx;
            end

            DONE: begin
               state_d = IDLE;
            end

            default: begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Outputs decoded from state. Strobes to the counter bank are gated by
   // ScanAbort so an abort takes effect within the same cycle.
   // -------------------------------------------------------------------------
   always_comb begin
      read_en  = (state_q == SELECT) && !ScanAbort;
      clear_en = (state_q == CLEAR)  && !ScanAbort;
      Busy     = (state_q != IDLE);
      ScanDone = (state_q == DONE)   && !ScanAbort;
   end

   error_scan_onehot_dec #(
      .NUM_CNT (NUM_CNT),
      .IDX_W   (IDX_W)
   ) u_onehot_dec (
      .idx       (idx_q),
      .read_en   (read_en),
      .clear_en  (clear_en),
      .read_vec  (ErrorRead),
      .clear_vec (ErrorReset)
   );

   assign DataValid = valid_q;
   assign DataIdx   = data_idx_q;
   assign DataCount = data_count_q;
   assign AnyError  = any_error_q;

endmodule : error_counter_scanner
